// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// pipeline_hazard_ctrl_pkg : state and control-bundle types for hazard control
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_HALTED = 2'd2
    } hz_state_e;

    // stall/flush bit order: [3]=IF_ID [2]=ID_EX [1]=EX_MEM [0]=MEM_WB
    typedef struct packed {
        logic       pc_write_en;
        logic [3:0] stall;
        logic [3:0] flush;
        logic       halted;
    } hz_ctrl_t;

    localparam hz_ctrl_t c_CTRL_NONE   = '{pc_write_en: 1'b0, stall: 4'b0000, flush: 4'b0000, halted: 1'b0};
    localparam hz_ctrl_t c_CTRL_RUN    = '{pc_write_en: 1'b1, stall: 4'b0000, flush: 4'b0000, halted: 1'b0};
    localparam hz_ctrl_t c_CTRL_DWAIT  = '{pc_write_en: 1'b0, stall: 4'b1111, flush: 4'b0000, halted: 1'b0};
    localparam hz_ctrl_t c_CTRL_MISP   = '{pc_write_en: 1'b1, stall: 4'b0000, flush: 4'b1100, halted: 1'b0};
    localparam hz_ctrl_t c_CTRL_LDUSE  = '{pc_write_en: 1'b0, stall: 4'b1000, flush: 4'b0100, halted: 1'b0};
    localparam hz_ctrl_t c_CTRL_JUMP   = '{pc_write_en: 1'b1, stall: 4'b0000, flush: 4'b1000, halted: 1'b0};
    localparam hz_ctrl_t c_CTRL_BUBBLE = '{pc_write_en: 1'b0, stall: 4'b0000, flush: 4'b1000, halted: 1'b0};
    localparam hz_ctrl_t c_CTRL_HALTED = '{pc_write_en: 1'b0, stall: 4'b1111, flush: 4'b0000, halted: 1'b1};

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ============================================================================
// hazard_sat_counter : saturating up-counter with synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush/PC-enable generation and HLT drain FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [RA_W-1:0]  rs_ID,
    input  logic [RA_W-1:0]  rt_ID,
    input  logic             use_rs_ID,
    input  logic             use_rt_ID,
    input  logic             jump_ID,
    input  logic             is_halted_ID,
    input  logic             d_readM_EX,
    input  logic [RA_W-1:0]  write_reg_EX,
    input  logic             mispredict_EX,
    input  logic             i_req,
    input  logic             i_ready,
    input  logic             d_req_MEM,
    input  logic             d_ready,
    input  logic             is_halted_WB,
    output logic             pc_write_en,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             stall_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e r_state;
    hz_state_e w_state_nxt;
    hz_ctrl_t  w_ctrl;
    logic      w_load_use;
    logic      w_d_wait;
    logic      w_i_wait;
    logic      w_stall_inc;
    logic      w_flush_inc;

    assign w_load_use = d_readM_EX &
                        ((use_rs_ID & (rs_ID == write_reg_EX)) |
                         (use_rt_ID & (rt_ID == write_reg_EX)));
    assign w_d_wait   = d_req_MEM & ~d_ready;
    assign w_i_wait   = i_req & ~i_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_ctrl      = c_CTRL_RUN;
        w_state_nxt = r_state;
        unique case (r_state)
            HZ_RUN: begin
                if (w_d_wait) begin
                    w_ctrl = c_CTRL_DWAIT;
                end else if (mispredict_EX) begin
                    w_ctrl = c_CTRL_MISP;
                end else if (w_load_use) begin
                    w_ctrl = c_CTRL_LDUSE;
                end else if (jump_ID) begin
                    w_ctrl = c_CTRL_JUMP;
                end else if (w_i_wait) begin
                    w_ctrl = c_CTRL_BUBBLE;
                    if (is_halted_ID) w_state_nxt = HZ_DRAIN;
                end else begin
                    w_ctrl = c_CTRL_RUN;
                    if (is_halted_ID) w_state_nxt = HZ_DRAIN;
                end
            end
            HZ_DRAIN: begin
                // HLT reaching WB is older than the branch in EX, so it wins
                if (w_d_wait) begin
                    w_ctrl = c_CTRL_DWAIT;
                end else if (is_halted_WB) begin
                    w_ctrl      = c_CTRL_BUBBLE;
                    w_state_nxt = HZ_HALTED;
                end else if (mispredict_EX) begin
                    w_ctrl      = c_CTRL_MISP;
                    w_state_nxt = HZ_RUN;
                end else begin
                    w_ctrl = c_CTRL_BUBBLE;
                end
            end
            HZ_HALTED: begin
                w_ctrl = c_CTRL_HALTED;
            end
            default: begin
                w_ctrl      = c_CTRL_NONE;
                w_state_nxt = HZ_RUN;
            end
        endcase
        if (!reset_n) begin
            w_ctrl = c_CTRL_NONE;
        end
    end

    assign pc_write_en  = w_ctrl.pc_write_en;
    assign stall_IF_ID  = w_ctrl.stall[3];
    assign stall_ID_EX  = w_ctrl.stall[2];
    assign stall_EX_MEM = w_ctrl.stall[1];
    assign stall_MEM_WB = w_ctrl.stall[0];
    assign flush_IF_ID  = w_ctrl.flush[3];
    assign flush_ID_EX  = w_ctrl.flush[2];
    assign flush_EX_MEM = w_ctrl.flush[1];
    assign flush_MEM_WB = w_ctrl.flush[0];
    assign halted       = w_ctrl.halted;

    assign w_stall_inc = reset_n & ~w_ctrl.pc_write_en & (r_state != HZ_HALTED);
    assign w_flush_inc = reset_n & (|w_ctrl.flush);

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .i_inc   (w_stall_inc),
        .i_clear (~reset_n),
        .o_count (stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .i_inc   (w_flush_inc),
        .i_clear (~reset_n),
        .o_count (flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : vector table plus corner sequences for hazard ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int RA_W  = 2;

    typedef struct packed {
        logic [1:0] rs, rt;
        logic       urs, urt, jmp, hid, ld;
        logic [1:0] wr;
        logic       mp, irq, ird, drq, drd, hwb;
    } in_t;

    typedef struct {
        in_t        i;
        logic [9:0] e;
        string      nm;
    } vec_t;

    // expected {pc_we, stall IF_ID..MEM_WB, flush IF_ID..MEM_WB, halted}
    localparam logic [9:0] E_RUN   = 10'b1_0000_0000_0;
    localparam logic [9:0] E_DWAIT = 10'b0_1111_0000_0;
    localparam logic [9:0] E_MISP  = 10'b1_0000_1100_0;
    localparam logic [9:0] E_LU    = 10'b0_1000_0100_0;
    localparam logic [9:0] E_JMP   = 10'b1_0000_1000_0;
    localparam logic [9:0] E_IW    = 10'b0_0000_1000_0;
    localparam logic [9:0] E_DRAIN = 10'b0_0000_1000_0;
    localparam logic [9:0] E_HALT  = 10'b0_1111_0000_1;
    localparam logic [9:0] E_RST   = 10'b0_0000_0000_0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [RA_W-1:0] rs_ID, rt_ID, write_reg_EX;
    logic use_rs_ID, use_rt_ID, jump_ID, is_halted_ID, d_readM_EX, mispredict_EX;
    logic i_req, i_ready, d_req_MEM, d_ready, is_halted_WB;
    logic pc_write_en, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
    logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic [9:0] exp_q[$];
    string      nm_q[$];
    vec_t       tbl[15];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .RA_W(RA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
        .jump_ID(jump_ID), .is_halted_ID(is_halted_ID), .d_readM_EX(d_readM_EX),
        .write_reg_EX(write_reg_EX), .mispredict_EX(mispredict_EX),
        .i_req(i_req), .i_ready(i_ready), .d_req_MEM(d_req_MEM), .d_ready(d_ready),
        .is_halted_WB(is_halted_WB), .pc_write_en(pc_write_en),
        .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
        .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic in_t mk(input logic [1:0] rs, input logic [1:0] rt,
                               input logic urs, input logic urt, input logic jmp,
                               input logic hid, input logic ld, input logic [1:0] wr,
                               input logic mp, input logic irq, input logic ird,
                               input logic drq, input logic drd, input logic hwb);
        in_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.jmp = jmp; v.hid = hid;
        v.ld = ld; v.wr = wr; v.mp = mp; v.irq = irq; v.ird = ird;
        v.drq = drq; v.drd = drd; v.hwb = hwb;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic apply(input in_t v);
        rs_ID = v.rs; rt_ID = v.rt; use_rs_ID = v.urs; use_rt_ID = v.urt;
        jump_ID = v.jmp; is_halted_ID = v.hid; d_readM_EX = v.ld; write_reg_EX = v.wr;
        mispredict_EX = v.mp; i_req = v.irq; i_ready = v.ird;
        d_req_MEM = v.drq; d_ready = v.drd; is_halted_WB = v.hwb;
    endtask

    function automatic logic [9:0] outs();
        return {pc_write_en, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Pops the expected bundle, checks outputs and counters, then advances the counter model.
    task automatic check_out();
        logic [9:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        cmp({nm, " outs"}, {22'd0, outs()}, {22'd0, e});
        cmp({nm, " stall_cnt"}, {16'd0, stall_cnt}, {16'd0, m_stall});
        cmp({nm, " flush_cnt"}, {16'd0, flush_cnt}, {16'd0, m_flush});
        if (!e[0]) begin
            if (!e[9] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if ((|e[4:1]) && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
    endtask

    task automatic step(input in_t v, input logic [9:0] e, input string nm);
        @(posedge clk); #1;
        reset_n = 1'b1;
        apply(v);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk); #1;
        reset_n = 1'b0;
        apply(idle());
        @(negedge clk);
        cmp({nm, " rst outs"}, {22'd0, outs()}, {22'd0, E_RST});
        @(posedge clk); #1;
        apply(mk(2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        cmp({nm, " rst outs busy"}, {22'd0, outs()}, {22'd0, E_RST});
        cmp({nm, " rst stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
        cmp({nm, " rst flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
        m_stall = '0;
        m_flush = '0;
    endtask

    initial begin
        apply(idle());
        //              rs    rt    urs   urt   jmp   hid   ld    wr    mp    irq   ird   drq   drd   hwb
        tbl[0]  = '{mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_RUN,   "idle"};
        tbl[1]  = '{mk(2'd1,2'd0,1'b1,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_LU,    "lu_rs"};
        tbl[2]  = '{mk(2'd0,2'd2,1'b0,1'b1,1'b0,1'b0,1'b1,2'd2,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_LU,    "lu_rt"};
        tbl[3]  = '{mk(2'd1,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_RUN,   "lu_nouse"};
        tbl[4]  = '{mk(2'd1,2'd2,1'b1,1'b1,1'b0,1'b0,1'b1,2'd3,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_RUN,   "lu_nomatch"};
        tbl[5]  = '{mk(2'd1,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_RUN,   "noload"};
        tbl[6]  = '{mk(2'd1,2'd0,1'b1,1'b0,1'b0,1'b0,1'b1,2'd1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0), E_MISP,  "misp_lu"};
        tbl[7]  = '{mk(2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd3,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0), E_MISP,  "misp_jmp"};
        tbl[8]  = '{mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0), E_DWAIT, "dwait_misp"};
        tbl[9]  = '{mk(2'd1,2'd0,1'b1,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0), E_DWAIT, "dwait_lu"};
        tbl[10] = '{mk(2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd3,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0), E_JMP,   "jmp_iwait"};
        tbl[11] = '{mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0), E_IW,    "iwait"};
        tbl[12] = '{mk(2'd2,2'd0,1'b1,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0), E_LU,    "lu_iwait"};
        tbl[13] = '{mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0), E_RUN,   "dreq_done"};
        tbl[14] = '{mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0), E_MISP,  "misp_iwait"};

        do_reset("init");
        for (int k = 0; k < 15; k++) step(tbl[k].i, tbl[k].e, tbl[k].nm);

        // d_wait holds a mispredict for 3 cycles, then the flush pair fires
        do_reset("r_dw");
        for (int k = 0; k < 3; k++) step(tbl[8].i, E_DWAIT, "dw3");
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0), E_MISP, "dw3_release");
        step(idle(), E_RUN, "dw3_after");

        // two i_wait cycles from reset: flush_cnt reaches 2
        do_reset("r_iw");
        step(tbl[11].i, E_IW, "iw2_a");
        step(tbl[11].i, E_IW, "iw2_b");
        step(idle(), E_RUN, "iw2_end");
        cmp("iw2 flush_cnt", {16'd0, flush_cnt}, 32'd2);

        // HLT under load-use is stalled, so no drain starts
        do_reset("r_hlu");
        step(mk(2'd1,2'd0,1'b1,1'b0,1'b0,1'b1,1'b1,2'd1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_LU, "hlt_lu");
        step(idle(), E_RUN, "hlt_lu_next");

        // HLT drain into HALTED; mispredict cannot leave HALTED
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd3,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_RUN, "hlt_id");
        step(idle(), E_DRAIN, "drain1");
        step(tbl[11].i, E_DRAIN, "drain2");
        step(tbl[8].i, E_DWAIT, "drain_dwait");
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1), E_DRAIN, "hlt_wb");
        step(idle(), E_HALT, "halt1");
        step(tbl[7].i, E_HALT, "halt_misp");
        step(tbl[11].i, E_HALT, "halt_iw");

        // wrong-path HLT: mispredict in DRAIN returns to RUN
        do_reset("r_wp");
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd3,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0), E_IW, "hlt_iw");
        step(idle(), E_DRAIN, "wp_drain");
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0), E_MISP, "wp_misp");
        step(idle(), E_RUN, "wp_run");

        // WB halt and mispredict together in DRAIN: halt wins
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd3,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_RUN, "hw_hlt_id");
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1), E_DRAIN, "hw_both");
        step(idle(), E_HALT, "hw_halted");

        // reset in the middle of DRAIN
        do_reset("r_md");
        step(mk(2'd0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd3,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0), E_RUN, "md_hlt");
        step(idle(), E_DRAIN, "md_drain");
        do_reset("r_md2");
        step(idle(), E_RUN, "md_run");

        // saturation: 2^CNT_W+5 d_wait cycles
        do_reset("r_sat");
        for (int k = 0; k < (1 << CNT_W) + 5; k++) step(tbl[8].i, E_DWAIT, "sat");
        step(idle(), E_RUN, "sat_end");
        cmp("sat stall_cnt max", {16'd0, stall_cnt}, 32'h0000FFFF);
        cmp("sat flush_cnt", {16'd0, flush_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
